// File: rtl/timer1_pkg.sv
// rtl/timer1_pkg.sv - Timer 1 mode encodings shared by the controller and its bench
package timer1_pkg;

  localparam logic [1:0] MODE_13BIT      = 2'b00;
  localparam logic [1:0] MODE_16BIT      = 2'b01;
  localparam logic [1:0] MODE_AUTORELOAD = 2'b10;
  localparam logic [1:0] MODE_HALT       = 2'b11;

endpackage

// File: rtl/baud_divider.sv
// rtl/baud_divider.sv - turns Timer 1 overflows into UART oversample and bit ticks
module baud_divider #(
  parameter int OVS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic ovf,
  input  logic smod,
  input  logic run,
  output logic tick16,
  output logic baud_tick
);

  localparam int OW = $clog2(OVS);
  localparam logic [OW-1:0] OS_MAX = OW'(OVS - 1);

  logic          half_q, half_d;
  logic [OW-1:0] os_q, os_d;
  logic          tick16_q, tick16_d;
  logic          baud_q, baud_d;
  logic          fire;

  // Without SMOD every second overflow fires (half-flop 1->0); every OVS-th fire is a bit tick
  always_comb begin
    half_d   = half_q;
    os_d     = os_q;
    fire     = run && ovf && (smod || half_q);
    if (run && ovf && !smod) begin
      half_d = ~half_q;
    end
    if (fire) begin
      os_d = (os_q == OS_MAX) ? '0 : os_q + 1'b1;
    end
    tick16_d = fire;
    baud_d   = fire && (os_q == OS_MAX);
  end

  // Divider state and registered tick pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_q   <= 1'b0;
      os_q     <= '0;
      tick16_q <= 1'b0;
      baud_q   <= 1'b0;
    end else begin
      half_q   <= half_d;
      os_q     <= os_d;
      tick16_q <= tick16_d;
      baud_q   <= baud_d;
    end
  end

  assign tick16    = tick16_q;
  assign baud_tick = baud_q;

endmodule

// File: rtl/timer1_baud_ctrl.sv
// rtl/timer1_baud_ctrl.sv - Timer 1 prescaler, counter modes, TF1 flag and baud tick generation
module timer1_baud_ctrl
  import timer1_pkg::*;
#(
  parameter int PRESCALE = 12,
  parameter int OVS      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tr1,
  input  logic [1:0] mode,
  input  logic       smod,
  input  logic       cfg_we,
  input  logic [7:0] cfg_th1,
  input  logic [7:0] cfg_tl1,
  input  logic       tf1_clr,
  output logic [7:0] tl1,
  output logic [7:0] th1,
  output logic       tf1,
  output logic       tick16,
  output logic       baud_tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    tl1_q, tl1_d;
  logic [7:0]    th1_q, th1_d;
  logic          tf1_q, tf1_d;
  logic          inc;
  logic          ovf;

  // Prescaler, counter increment per mode, config load priority and flag set/clear
  always_comb begin
    presc_d = presc_q;
    tl1_d   = tl1_q;
    th1_d   = th1_q;
    ovf     = 1'b0;
    inc     = tr1 && (presc_q == PRESC_MAX) && (mode != MODE_HALT);

    if (tr1) begin
      presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
    end

    // A CPU load wins over a same-cycle increment and suppresses its overflow
    if (cfg_we) begin
      presc_d = '0;
      tl1_d   = cfg_tl1;
      th1_d   = cfg_th1;
    end else if (inc) begin
      case (mode)
        MODE_13BIT: begin
          {th1_d, tl1_d[4:0]} = {th1_q, tl1_q[4:0]} + 13'd1;
          ovf = ({th1_q, tl1_q[4:0]} == 13'h1FFF);
        end
        MODE_16BIT: begin
          {th1_d, tl1_d} = {th1_q, tl1_q} + 16'd1;
          ovf = ({th1_q, tl1_q} == 16'hFFFF);
        end
        MODE_AUTORELOAD: begin
          if (tl1_q == 8'hFF) begin
            tl1_d = th1_q;
            ovf   = 1'b1;
          end else begin
            tl1_d = tl1_q + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end

    // Overflow beats a same-cycle clear so no overflow event is lost
    if (ovf) begin
      tf1_d = 1'b1;
    end else if (tf1_clr) begin
      tf1_d = 1'b0;
    end else begin
      tf1_d = tf1_q;
    end
  end

  // Timer state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      tl1_q   <= 8'h00;
      th1_q   <= 8'h00;
      tf1_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tl1_q   <= tl1_d;
      th1_q   <= th1_d;
      tf1_q   <= tf1_d;
    end
  end

  baud_divider #(
    .OVS(OVS)
  ) u_baud_divider (
    .clk      (clk),
    .rst      (rst),
    .ovf      (ovf),
    .smod     (smod),
    .run      (tr1),
    .tick16   (tick16),
    .baud_tick(baud_tick)
  );

  assign tl1 = tl1_q;
  assign th1 = th1_q;
  assign tf1 = tf1_q;

endmodule
